custom_fifo_rd_ctrl: RTL and testbench

Read-side controller for the team's asynchronous FIFO, operating entirely in the read clock domain. It synchronizes the write-domain Gray pointer, maintains the read pointer, generates the registered empty flag and the read address for the FIFO memory, and presents popped words on a registered valid/ready output port. It pairs with the write-side pointer/full logic and drives the memory's `rd_addr`, `ren` and `fifo_empty` inputs.

---
 rtl/custom_fifo_rd_ctrl.sv | 116 +++++++++++
 tb/tb_custom_fifo_rd_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/custom_fifo_rd_ctrl.sv
// Read-side controller for the asynchronous FIFO: synchronizes the write Gray pointer,
// owns the read pointer and empty flag, and presents popped words on a valid/ready port.
module custom_fifo_rd_ctrl #(
    parameter int ADDRSIZE = 4,
    parameter int DATASIZE = 8
) (
    input  logic                rclk_i,
    input  logic                rrst_n_i,
    input  logic [ADDRSIZE:0]   wptr_gray_i,
    input  logic [DATASIZE-1:0] mem_dout_i,
    input  logic                dready_i,
    output logic [ADDRSIZE-1:0] rd_addr_o,
    output logic [ADDRSIZE:0]   rptr_gray_o,
    output logic                ren_o,
    output logic                fifo_empty_o,
    output logic [DATASIZE-1:0] dout_o,
    output logic                dvalid_o,
    output logic [ADDRSIZE:0]   rlevel_o
);

    localparam int PW = ADDRSIZE + 1;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [PW-1:0]       wq1_r;
    logic [PW-1:0]       wq2_r;
    logic [PW-1:0]       rbin_r;
    logic [PW-1:0]       rgray_r;
    logic                empty_r;
    logic [DATASIZE-1:0] dout_r;
    logic                dvalid_r;

    logic                pop_s;
    logic [PW-1:0]       rbin_next_s;
    logic [PW-1:0]       rgray_next_s;
    logic                empty_next_s;
    logic [PW-1:0]       level_s;

    // Pop decision, next read pointer and next empty state.
    always_comb begin
        pop_s        = 1'b0;
        rbin_next_s  = rbin_r;
        rgray_next_s = rgray_r;
        empty_next_s = 1'b1;
        level_s      = {PW{1'b0}};

        pop_s        = ~empty_r & (~dvalid_r | dready_i);
        rbin_next_s  = rbin_r + {{ADDRSIZE{1'b0}}, pop_s};
        rgray_next_s = bin2gray(rbin_next_s);
        // Compared against the current synchronized pointer: may be pessimistically empty
        // for one cycle but never falsely non-empty.
        empty_next_s = (rgray_next_s == wq2_r);
        level_s      = gray2bin(wq2_r) - rbin_r;
    end

    // Two-flop synchronizer for the write-domain Gray pointer.
    always_ff @(posedge rclk_i or negedge rrst_n_i) begin
        if (!rrst_n_i) begin
            wq1_r <= {PW{1'b0}};
            wq2_r <= {PW{1'b0}};
        end else begin
            wq1_r <= wptr_gray_i;
            wq2_r <= wq1_r;
        end
    end

    // Read pointer (binary and Gray) and registered empty flag.
    always_ff @(posedge rclk_i or negedge rrst_n_i) begin
        if (!rrst_n_i) begin
            rbin_r  <= {PW{1'b0}};
            rgray_r <= {PW{1'b0}};
            empty_r <= 1'b1;
        end else begin
            rbin_r  <= rbin_next_s;
            rgray_r <= rgray_next_s;
            empty_r <= empty_next_s;
        end
    end

    // Output data register: loads on pop, holds while stalled, drops valid once taken.
    always_ff @(posedge rclk_i or negedge rrst_n_i) begin
        if (!rrst_n_i) begin
            dout_r   <= {DATASIZE{1'b0}};
            dvalid_r <= 1'b0;
        end else if (pop_s) begin
            dout_r   <= mem_dout_i;
            dvalid_r <= 1'b1;
        end else if (dready_i) begin
            dout_r   <= dout_r;
            dvalid_r <= 1'b0;
        end else begin
            dout_r   <= dout_r;
            dvalid_r <= dvalid_r;
        end
    end

    assign rd_addr_o    = rbin_r[ADDRSIZE-1:0];
    assign rptr_gray_o  = rgray_r;
    assign ren_o        = pop_s;
    assign fifo_empty_o = empty_r;
    assign dout_o       = dout_r;
    assign dvalid_o     = dvalid_r;
    assign rlevel_o     = level_s;

endmodule

// File: tb/tb_custom_fifo_rd_ctrl.sv
// Directed self-checking bench for custom_fifo_rd_ctrl (ADDRSIZE=4, DATASIZE=8)
// with a combinational memory model indexed by rd_addr_o.
module tb_custom_fifo_rd_ctrl;

    logic       rclk_i = 1'b0;
    logic       rrst_n_i;
    logic [4:0] wptr_gray_i;
    logic [7:0] mem_dout_i;
    logic       dready_i;
    logic [3:0] rd_addr_o;
    logic [4:0] rptr_gray_o;
    logic       ren_o;
    logic       fifo_empty_o;
    logic [7:0] dout_o;
    logic       dvalid_o;
    logic [4:0] rlevel_o;

    logic [7:0] mem [16];
    logic [4:0] wcnt;
    int n_vec = 0;
    int n_err = 0;

    custom_fifo_rd_ctrl #(.ADDRSIZE(4), .DATASIZE(8)) dut (
        .rclk_i       (rclk_i),
        .rrst_n_i     (rrst_n_i),
        .wptr_gray_i  (wptr_gray_i),
        .mem_dout_i   (mem_dout_i),
        .dready_i     (dready_i),
        .rd_addr_o    (rd_addr_o),
        .rptr_gray_o  (rptr_gray_o),
        .ren_o        (ren_o),
        .fifo_empty_o (fifo_empty_o),
        .dout_o       (dout_o),
        .dvalid_o     (dvalid_o),
        .rlevel_o     (rlevel_o)
    );

    assign mem_dout_i = mem[rd_addr_o];

    always #5 rclk_i = ~rclk_i;

    function automatic logic [4:0] to_gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge rclk_i);
        #1;
    endtask

    task automatic set_wcnt(input logic [4:0] v);
        wcnt        = v;
        wptr_gray_i = to_gray(v);
    endtask

    task automatic do_reset();
        @(posedge rclk_i);
        #2;
        rrst_n_i = 1'b0;
        dready_i = 1'b0;
        set_wcnt(5'd0);
        #2;
        rrst_n_i = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        mem[0] = 8'h5C;
        set_wcnt(5'd2);
        repeat (4) tick();
        n_vec++; if (dvalid_o !== 1'b1) begin n_err++; $display("FAIL rst_pre_dvalid: got %b want 1", dvalid_o); end
        n_vec++; if (fifo_empty_o !== 1'b0) begin n_err++; $display("FAIL rst_pre_empty: got %b want 0", fifo_empty_o); end
        #2;
        rrst_n_i = 1'b0;
        set_wcnt(5'd0);
        #1;
        n_vec++; if (fifo_empty_o !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b want 1", fifo_empty_o); end
        n_vec++; if (dvalid_o !== 1'b0) begin n_err++; $display("FAIL rst_dvalid: got %b want 0", dvalid_o); end
        n_vec++; if (rd_addr_o !== 4'd0) begin n_err++; $display("FAIL rst_addr: got %h want 0", rd_addr_o); end
        n_vec++; if (rptr_gray_o !== 5'd0) begin n_err++; $display("FAIL rst_rptr: got %b want 00000", rptr_gray_o); end
        n_vec++; if (rlevel_o !== 5'd0) begin n_err++; $display("FAIL rst_level: got %0d want 0", rlevel_o); end
        n_vec++; if (ren_o !== 1'b0) begin n_err++; $display("FAIL rst_ren: got %b want 0", ren_o); end
        n_vec++; if (dout_o !== 8'h00) begin n_err++; $display("FAIL rst_dout: got %h want 00", dout_o); end
        #2;
        rrst_n_i = 1'b1;
        repeat (3) tick();
        n_vec++; if (fifo_empty_o !== 1'b1) begin n_err++; $display("FAIL rst_hold_empty: got %b want 1", fifo_empty_o); end
        n_vec++; if (dvalid_o !== 1'b0) begin n_err++; $display("FAIL rst_hold_dvalid: got %b want 0", dvalid_o); end
        n_vec++; if (rptr_gray_o !== 5'd0) begin n_err++; $display("FAIL rst_hold_rptr: got %b want 00000", rptr_gray_o); end
        n_vec++; if (rlevel_o !== 5'd0) begin n_err++; $display("FAIL rst_hold_level: got %0d want 0", rlevel_o); end
    endtask

    task automatic test_single_word();
        do_reset();
        mem[0]   = 8'hA5;
        dready_i = 1'b1;
        set_wcnt(5'd1);
        tick();
        n_vec++; if (fifo_empty_o !== 1'b1) begin n_err++; $display("FAIL sw_empty_n0: got %b want 1", fifo_empty_o); end
        tick();
        n_vec++; if (fifo_empty_o !== 1'b1) begin n_err++; $display("FAIL sw_empty_n1: got %b want 1", fifo_empty_o); end
        n_vec++; if (rlevel_o !== 5'd1) begin n_err++; $display("FAIL sw_level_n1: got %0d want 1", rlevel_o); end
        n_vec++; if (ren_o !== 1'b0) begin n_err++; $display("FAIL sw_ren_n1: got %b want 0", ren_o); end
        tick();
        n_vec++; if (fifo_empty_o !== 1'b0) begin n_err++; $display("FAIL sw_empty_n2: got %b want 0", fifo_empty_o); end
        n_vec++; if (ren_o !== 1'b1) begin n_err++; $display("FAIL sw_ren_n2: got %b want 1", ren_o); end
        tick();
        n_vec++; if (dout_o !== 8'hA5) begin n_err++; $display("FAIL sw_dout: got %h want a5", dout_o); end
        n_vec++; if (dvalid_o !== 1'b1) begin n_err++; $display("FAIL sw_dvalid: got %b want 1", dvalid_o); end
        n_vec++; if (fifo_empty_o !== 1'b1) begin n_err++; $display("FAIL sw_empty_n3: got %b want 1", fifo_empty_o); end
        n_vec++; if (ren_o !== 1'b0) begin n_err++; $display("FAIL sw_ren_n3: got %b want 0", ren_o); end
        n_vec++; if (rptr_gray_o !== 5'b00001) begin n_err++; $display("FAIL sw_rptr: got %b want 00001", rptr_gray_o); end
        n_vec++; if (rlevel_o !== 5'd0) begin n_err++; $display("FAIL sw_level_n3: got %0d want 0", rlevel_o); end
        tick();
        n_vec++; if (dvalid_o !== 1'b0) begin n_err++; $display("FAIL sw_dvalid_drop: got %b want 0", dvalid_o); end
    endtask

    task automatic test_back_pressure();
        do_reset();
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
        dready_i = 1'b0;
        set_wcnt(5'd3);
        repeat (3) tick();
        n_vec++; if (ren_o !== 1'b1) begin n_err++; $display("FAIL bp_first_ren: got %b want 1", ren_o); end
        tick();
        n_vec++; if (dout_o !== 8'h11) begin n_err++; $display("FAIL bp_dout0: got %h want 11", dout_o); end
        n_vec++; if (dvalid_o !== 1'b1) begin n_err++; $display("FAIL bp_dvalid0: got %b want 1", dvalid_o); end
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (ren_o !== 1'b0) begin n_err++; $display("FAIL bp_stall_ren: got %b want 0", ren_o); end
            n_vec++; if (dout_o !== 8'h11) begin n_err++; $display("FAIL bp_stall_dout: got %h want 11", dout_o); end
            tick();
        end
        dready_i = 1'b1;
        #1;
        n_vec++; if (ren_o !== 1'b1) begin n_err++; $display("FAIL bp_resume_ren: got %b want 1", ren_o); end
        tick();
        n_vec++; if (dout_o !== 8'h22) begin n_err++; $display("FAIL bp_dout1: got %h want 22", dout_o); end
        n_vec++; if (ren_o !== 1'b1) begin n_err++; $display("FAIL bp_ren1: got %b want 1", ren_o); end
        tick();
        n_vec++; if (dout_o !== 8'h33) begin n_err++; $display("FAIL bp_dout2: got %h want 33", dout_o); end
        n_vec++; if (fifo_empty_o !== 1'b1) begin n_err++; $display("FAIL bp_empty: got %b want 1", fifo_empty_o); end
        n_vec++; if (ren_o !== 1'b0) begin n_err++; $display("FAIL bp_ren_end: got %b want 0", ren_o); end
        tick();
        n_vec++; if (dvalid_o !== 1'b0) begin n_err++; $display("FAIL bp_dvalid_end: got %b want 0", dvalid_o); end
    endtask

    task automatic test_full_drain();
        int rx;
        logic [4:0] prev;
        do_reset();
        for (int i = 0; i < 16; i++) mem[i] = 8'(8'h40 + i);
        dready_i = 1'b1;
        set_wcnt(5'd16);
        repeat (2) tick();
        n_vec++; if (rlevel_o !== 5'd16) begin n_err++; $display("FAIL fd_level: got %0d want 16", rlevel_o); end
        rx = 0;
        for (int c = 0; c < 24; c++) begin
            prev = rptr_gray_o;
            tick();
            n_vec++; if ($countones(prev ^ rptr_gray_o) > 1) begin n_err++; $display("FAIL fd_gray_step: got %b->%b want <=1 bit", prev, rptr_gray_o); end
            if (dvalid_o) begin
                n_vec++; if (dout_o !== 8'(8'h40 + rx)) begin n_err++; $display("FAIL fd_data: got %h want %h", dout_o, 8'(8'h40 + rx)); end
                rx++;
            end
        end
        n_vec++; if (rx !== 16) begin n_err++; $display("FAIL fd_count: got %0d want 16", rx); end
        n_vec++; if (rd_addr_o !== 4'd0) begin n_err++; $display("FAIL fd_addr: got %h want 0", rd_addr_o); end
        n_vec++; if (rptr_gray_o !== 5'b11000) begin n_err++; $display("FAIL fd_rptr: got %b want 11000", rptr_gray_o); end
        n_vec++; if (fifo_empty_o !== 1'b1) begin n_err++; $display("FAIL fd_empty: got %b want 1", fifo_empty_o); end
        n_vec++; if (rlevel_o !== 5'd0) begin n_err++; $display("FAIL fd_level_end: got %0d want 0", rlevel_o); end
    endtask

    task automatic test_wrap();
        int rx;
        int k;
        logic [4:0] prev;
        logic saw_wrap;
        do_reset();
        dready_i = 1'b1;
        rx = 0;
        k = 0;
        saw_wrap = 1'b0;
        for (int c = 0; c < 100 && rx < 40; c++) begin
            if (k < 40) begin
                mem[wcnt[3:0]] = 8'(k * 7 + 3);
                set_wcnt(5'(wcnt + 5'd1));
                k++;
            end
            prev = rptr_gray_o;
            tick();
            if (prev == 5'b10000 && rptr_gray_o == 5'b00000) saw_wrap = 1'b1;
            n_vec++; if ($countones(prev ^ rptr_gray_o) > 1) begin n_err++; $display("FAIL wr_gray_step: got %b->%b want <=1 bit", prev, rptr_gray_o); end
            n_vec++; if (rlevel_o > 5'd16) begin n_err++; $display("FAIL wr_level: got %0d want <=16", rlevel_o); end
            if (dvalid_o) begin
                n_vec++; if (dout_o !== 8'(rx * 7 + 3)) begin n_err++; $display("FAIL wr_data: got %h want %h", dout_o, 8'(rx * 7 + 3)); end
                rx++;
            end
        end
        n_vec++; if (rx !== 40) begin n_err++; $display("FAIL wr_count: got %0d want 40", rx); end
        n_vec++; if (saw_wrap !== 1'b1) begin n_err++; $display("FAIL wr_wrap_seen: got %b want 1", saw_wrap); end
        n_vec++; if (rptr_gray_o !== 5'b01100) begin n_err++; $display("FAIL wr_rptr: got %b want 01100", rptr_gray_o); end
        n_vec++; if (fifo_empty_o !== 1'b1) begin n_err++; $display("FAIL wr_empty: got %b want 1", fifo_empty_o); end
    endtask

    task automatic test_reset_mid_stream();
        do_reset();
        for (int i = 0; i < 8; i++) mem[i] = 8'(8'h80 + i);
        dready_i = 1'b0;
        set_wcnt(5'd6);
        repeat (4) tick();
        n_vec++; if (dvalid_o !== 1'b1) begin n_err++; $display("FAIL rm_pre_dvalid: got %b want 1", dvalid_o); end
        n_vec++; if (rlevel_o !== 5'd5) begin n_err++; $display("FAIL rm_pre_level: got %0d want 5", rlevel_o); end
        #2;
        rrst_n_i = 1'b0;
        set_wcnt(5'd0);
        #1;
        n_vec++; if (dvalid_o !== 1'b0) begin n_err++; $display("FAIL rm_dvalid: got %b want 0", dvalid_o); end
        n_vec++; if (dout_o !== 8'h00) begin n_err++; $display("FAIL rm_dout: got %h want 00", dout_o); end
        n_vec++; if (fifo_empty_o !== 1'b1) begin n_err++; $display("FAIL rm_empty: got %b want 1", fifo_empty_o); end
        n_vec++; if (rlevel_o !== 5'd0) begin n_err++; $display("FAIL rm_level: got %0d want 0", rlevel_o); end
        n_vec++; if (rd_addr_o !== 4'd0) begin n_err++; $display("FAIL rm_addr: got %h want 0", rd_addr_o); end
        n_vec++; if (rptr_gray_o !== 5'd0) begin n_err++; $display("FAIL rm_rptr: got %b want 00000", rptr_gray_o); end
        n_vec++; if (ren_o !== 1'b0) begin n_err++; $display("FAIL rm_ren: got %b want 0", ren_o); end
        #2;
        rrst_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (ren_o !== 1'b0) begin n_err++; $display("FAIL rm_idle_ren: got %b want 0", ren_o); end
        end
        mem[0]   = 8'hC3;
        dready_i = 1'b1;
        set_wcnt(5'd1);
        tick();
        n_vec++; if (ren_o !== 1'b0) begin n_err++; $display("FAIL rm_new_ren_n0: got %b want 0", ren_o); end
        tick();
        n_vec++; if (ren_o !== 1'b0) begin n_err++; $display("FAIL rm_new_ren_n1: got %b want 0", ren_o); end
        tick();
        n_vec++; if (ren_o !== 1'b1) begin n_err++; $display("FAIL rm_new_ren_n2: got %b want 1", ren_o); end
        tick();
        n_vec++; if (dout_o !== 8'hC3) begin n_err++; $display("FAIL rm_new_dout: got %h want c3", dout_o); end
        n_vec++; if (dvalid_o !== 1'b1) begin n_err++; $display("FAIL rm_new_dvalid: got %b want 1", dvalid_o); end
    endtask

    initial begin
        rrst_n_i = 1'b0;
        dready_i = 1'b0;
        set_wcnt(5'd0);
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        #12;
        rrst_n_i = 1'b1;
        test_reset();
        test_single_word();
        test_back_pressure();
        test_full_drain();
        test_wrap();
        test_reset_mid_stream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
